// File: rtl/bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_scan_ctrl
//
// Purpose:
//   Converts a 10-bit binary value into four BCD digits with a serial
//   double-dabble (one shift per clock) and drives a 4-digit multiplexed,
//   active-low 7-segment display. The displayed digits only change on the
//   LATCH edge, so the old value stays up while a conversion runs.
//
// Ports:
//   clk   in   1   system clock
//   rst   in   1   synchronous active-high reset
//   bin   in  10   binary value 0..1023
//   load  in   1   conversion request (sampled every edge)
//   busy  out  1   conversion in progress
//   done  out  1   one-cycle pulse coincident with a new bcd value
//   bcd   out 16   latched digits {thousands, hundreds, tens, ones}
//   seg   out  7   segments {g,f,e,d,c,b,a}, active-low
//   an    out  4   digit enables, active-low; an[0]=ones, an[3]=thousands
//
// Build option:
//   BCD_SCAN_LZ_BLANK_EN - when defined, leading-zero digits (thousands,
//   hundreds, tens) are blanked: an=1111 and seg=1111111 for that slot.
//   Ones is never blanked. Undefined: all digits always shown.
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for load
//   CONV  | 10 add-3/shift steps of the double-dabble register
//   LATCH | publish bcd, pulse done, restart if a request is queued
// ---------------------------------------------------------------------------
module bcd_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  bin,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t      state;
    logic [25:0] shreg;
    logic [3:0]  step;
    logic        pending;
    logic [9:0]  pend_val;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_sel;

    logic [3:0] nib;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       blank;

    // One double-dabble step: correct every BCD nibble, then shift left.
    function automatic logic [25:0] dabble_step(input logic [25:0] r);
        logic [25:0] t;
        t = r;
        for (int i = 0; i < 4; i++) begin
            if (t[10 + 4*i +: 4] >= 4'd5)
                t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
        end
        return {t[24:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM. A load arriving on the LATCH edge takes priority over
    // the queued value, since it is the most recent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            step     <= '0;
            pending  <= 1'b0;
            pend_val <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= {16'b0, bin};
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= dabble_step(shreg);
                    step  <= step + 4'd1;
                    if (step == 4'd9)
                        state <= LATCH;
                    if (load) begin
                        pending  <= 1'b1;
                        pend_val <= bin;
                    end
                end
                LATCH: begin
                    bcd  <= shreg[25:10];
                    done <= 1'b1;
                    if (load) begin
                        shreg   <= {16'b0, bin};
                        step    <= '0;
                        pending <= 1'b0;
                        state   <= CONV;
                    end else if (pending) begin
                        shreg   <= {16'b0, pend_val};
                        step    <= '0;
                        pending <= 1'b0;
                        state   <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Refresh divider and digit rotation, free-running after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_sel   <= 2'd0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_sel   <= digit_sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        nib     = 4'h0;
        an_next = 4'b1111;
        blank   = 1'b0;
        case (digit_sel)
            2'd0: begin nib = bcd[3:0];   an_next = 4'b1110; end
            2'd1: begin nib = bcd[7:4];   an_next = 4'b1101; end
            2'd2: begin nib = bcd[11:8];  an_next = 4'b1011; end
            default: begin nib = bcd[15:12]; an_next = 4'b0111; end
        endcase
`ifdef BCD_SCAN_LZ_BLANK_EN
        case (digit_sel)
            2'd1:    blank = (bcd[15:4] == 12'h000);
            2'd2:    blank = (bcd[15:8] == 8'h00);
            2'd3:    blank = (bcd[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        if (blank) begin
            seg_next = 7'b1111111;
            an_next  = 4'b1111;
        end else begin
            seg_next = seg_decode(nib);
        end
    end

    // Display drive is registered, so it trails digit_sel by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
